set_time_ctrl: RTL and testbench

Button-driven time-setting controller for the four-digit HH:MM clock. It turns three raw push-buttons into the programming-side signals that the display path consumes: the edit digits DigB0..DigB3 and the programming flag prg. It also produces a one-cycle load strobe that commits the edited time into the timekeeping counter. It sits between the board buttons and the display/timekeeping blocks, as the input end of the same digit interface the display driver reads.

---
 rtl/set_time_pkg.sv | 37 +++
 rtl/btn_debounce.sv | 54 +++++
 rtl/set_time_ctrl.sv | 131 +++++++++++++
 tb/tb_set_time_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/set_time_pkg.sv
// Shared types, digit limits and edit-position encoding for the HH:MM time-setting controller.
package set_time_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EDIT   = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

    localparam logic [3:0] HT_MAX    = 4'd2;
    localparam logic [3:0] HU_MAX    = 4'd9;
    localparam logic [3:0] HU_MAX_20 = 4'd3;
    localparam logic [3:0] MT_MAX    = 4'd5;
    localparam logic [3:0] MU_MAX    = 4'd9;

    localparam logic [1:0] POS_HT = 2'd3;
    localparam logic [1:0] POS_HU = 2'd2;
    localparam logic [1:0] POS_MT = 2'd1;
    localparam logic [1:0] POS_MU = 2'd0;

    // Hours units are capped at 3 once hours tens reaches 2 (no 24:xx and above).
    function automatic logic [3:0] digit_max(input logic [1:0] pos, input logic [3:0] ht);
        logic [3:0] lim;
        case (pos)
            POS_HT:  lim = HT_MAX;
            POS_HU:  lim = (ht == HT_MAX) ? HU_MAX_20 : HU_MAX;
            POS_MT:  lim = MT_MAX;
            default: lim = MU_MAX;
        endcase
        return lim;
    endfunction

    function automatic logic [3:0] clip_digit(input logic [3:0] d, input logic [3:0] lim);
        return (d > lim) ? 4'd0 : d;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw button conditioning: 2-FF synchronizer, stability counter and registered rising-edge pulse.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset_,
    input  logic btn_i,
    output logic press_o
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    logic            sync1_q, sync2_q;
    logic            level_d, level_q;
    logic            level_prev_q;
    logic [CntW-1:0] cnt_d, cnt_q;
    logic            pulse_d, pulse_q;

    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        // Any sample matching the accepted level restarts the stability count.
        if (sync2_q != level_q) begin
            if (cnt_q == CntLast) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
        pulse_d = level_q & ~level_prev_q;
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            cnt_q        <= '0;
            pulse_q      <= 1'b0;
        end else begin
            sync1_q      <= btn_i;
            sync2_q      <= sync1_q;
            level_q      <= level_d;
            level_prev_q <= level_q;
            cnt_q        <= cnt_d;
            pulse_q      <= pulse_d;
        end
    end

    assign press_o = pulse_q;

endmodule

// File: rtl/set_time_ctrl.sv
// Button-driven HH:MM edit controller: snapshots the running time, edits it digit by digit,
// and strobes load to commit the edited digits.
module set_time_ctrl
    import set_time_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset_,
    input  logic       btn_mode,
    input  logic       btn_next,
    input  logic       btn_inc,
    input  logic [3:0] Dig0,
    input  logic [3:0] Dig1,
    input  logic [3:0] Dig2,
    input  logic [3:0] Dig3,
    output logic [3:0] DigB0,
    output logic [3:0] DigB1,
    output logic [3:0] DigB2,
    output logic [3:0] DigB3,
    output logic       prg,
    output logic [1:0] edit_pos,
    output logic       load
);

    logic mode_p, next_p, inc_p;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
        .clk     (clk),
        .reset_  (reset_),
        .btn_i   (btn_mode),
        .press_o (mode_p)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
        .clk     (clk),
        .reset_  (reset_),
        .btn_i   (btn_next),
        .press_o (next_p)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
        .clk     (clk),
        .reset_  (reset_),
        .btn_i   (btn_inc),
        .press_o (inc_p)
    );

    state_e           state_d, state_q;
    logic [1:0]       pos_d, pos_q;
    logic [3:0][3:0]  digb_d, digb_q;
    logic             prg_d, prg_q;
    logic             load_d, load_q;
    logic [3:0]       sel_digit;
    logic [3:0]       sel_max;

    assign sel_digit = digb_q[pos_q];
    assign sel_max   = digit_max(pos_q, digb_q[POS_HT]);

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        digb_d  = digb_q;
        unique case (state_q)
            ST_IDLE: begin
                if (mode_p) begin
                    state_d        = ST_EDIT;
                    pos_d          = POS_HT;
                    digb_d[POS_HT] = clip_digit(Dig3, HT_MAX);
                    digb_d[POS_HU] = clip_digit(Dig2, digit_max(POS_HU, digb_d[POS_HT]));
                    digb_d[POS_MT] = clip_digit(Dig1, MT_MAX);
                    digb_d[POS_MU] = clip_digit(Dig0, MU_MAX);
                end
            end
            ST_EDIT: begin
                if (mode_p) begin
                    state_d = ST_IDLE;
                    pos_d   = POS_HT;
                end else if (next_p) begin
                    if (pos_q == POS_MU) begin
                        state_d = ST_COMMIT;
                        pos_d   = POS_HT;
                    end else begin
                        pos_d = pos_q - 2'd1;
                    end
                end else if (inc_p) begin
                    digb_d[pos_q] = (sel_digit >= sel_max) ? 4'd0 : sel_digit + 4'd1;
                    // Stepping hours tens to 2 must pull an over-range hours units back to 3.
                    if ((pos_q == POS_HT) && (digb_d[POS_HT] == HT_MAX) &&
                        (digb_q[POS_HU] > HU_MAX_20)) begin
                        digb_d[POS_HU] = HU_MAX_20;
                    end
                end
            end
            ST_COMMIT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                pos_d   = POS_HT;
            end
        endcase
        prg_d  = (state_d == ST_EDIT);
        load_d = (state_d == ST_COMMIT);
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q <= ST_IDLE;
            pos_q   <= POS_HT;
            digb_q  <= '0;
            prg_q   <= 1'b0;
            load_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            digb_q  <= digb_d;
            prg_q   <= prg_d;
            load_q  <= load_d;
        end
    end

    assign DigB0    = digb_q[POS_MU];
    assign DigB1    = digb_q[POS_MT];
    assign DigB2    = digb_q[POS_HU];
    assign DigB3    = digb_q[POS_HT];
    assign prg      = prg_q;
    assign edit_pos = pos_q;
    assign load     = load_q;

endmodule

// File: tb/tb_set_time_ctrl.sv
// Self-checking bench for set_time_ctrl: directed scenarios plus randomized button traffic,
// compared each cycle against a behavioural model of the debounce and edit rules.
module tb_set_time_ctrl;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       reset_ = 1'b0;
    logic       btn_mode = 1'b0, btn_next = 1'b0, btn_inc = 1'b0;
    logic [3:0] Dig0 = 4'd0, Dig1 = 4'd0, Dig2 = 4'd0, Dig3 = 4'd0;
    logic [3:0] DigB0, DigB1, DigB2, DigB3;
    logic       prg, load;
    logic [1:0] edit_pos;

    int total = 0;
    int bad = 0;
    bit en = 0;

    always #5 clk = ~clk;

    set_time_ctrl #(.DEBOUNCE_CYCLES(N)) dut (
        .clk      (clk),
        .reset_   (reset_),
        .btn_mode (btn_mode),
        .btn_next (btn_next),
        .btn_inc  (btn_inc),
        .Dig0     (Dig0),
        .Dig1     (Dig1),
        .Dig2     (Dig2),
        .Dig3     (Dig3),
        .DigB0    (DigB0),
        .DigB1    (DigB1),
        .DigB2    (DigB2),
        .DigB3    (DigB3),
        .prg      (prg),
        .edit_pos (edit_pos),
        .load     (load)
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int digb_word();
        return {16'd0, DigB3, DigB2, DigB1, DigB0};
    endfunction

    // ---------------- behavioural model ----------------
    int m_mode;           // 0 idle, 1 edit, 2 commit
    int m_pos;
    int m_d[4];
    bit m_press[3];
    bit m_lvl[3], m_lvl_prev[3];
    bit m_h1[3], m_h2[3];
    bit m_win[3][$];
    bit m_raw[3];

    function automatic int lim(input int pos, input int ht);
        case (pos)
            3: return 2;
            2: return (ht == 2) ? 3 : 9;
            1: return 5;
            default: return 9;
        endcase
    endfunction

    task automatic model_reset();
        m_mode = 0;
        m_pos = 3;
        for (int i = 0; i < 4; i++) m_d[i] = 0;
        for (int b = 0; b < 3; b++) begin
            m_press[b] = 0; m_lvl[b] = 0; m_lvl_prev[b] = 0;
            m_h1[b] = 0; m_h2[b] = 0; m_win[b].delete();
        end
    endtask

    task automatic model_fsm(input bit pm, input bit pn, input bit pi);
        case (m_mode)
            0: if (pm) begin
                m_mode = 1;
                m_pos = 3;
                m_d[3] = (Dig3 > 2) ? 0 : int'(Dig3);
                m_d[2] = (int'(Dig2) > lim(2, m_d[3])) ? 0 : int'(Dig2);
                m_d[1] = (Dig1 > 5) ? 0 : int'(Dig1);
                m_d[0] = (Dig0 > 9) ? 0 : int'(Dig0);
            end
            1: if (pm) begin
                m_mode = 0;
                m_pos = 3;
            end else if (pn) begin
                if (m_pos == 0) begin
                    m_mode = 2;
                    m_pos = 3;
                end else begin
                    m_pos = m_pos - 1;
                end
            end else if (pi) begin
                m_d[m_pos] = (m_d[m_pos] == lim(m_pos, m_d[3])) ? 0 : m_d[m_pos] + 1;
                if (m_pos == 3 && m_d[3] == 2 && m_d[2] > 3) m_d[2] = 3;
            end
            default: m_mode = 0;
        endcase
    endtask

    always @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            model_reset();
        end else begin
            m_raw[0] = btn_mode; m_raw[1] = btn_next; m_raw[2] = btn_inc;
            model_fsm(m_press[0], m_press[1], m_press[2]);
            for (int b = 0; b < 3; b++) begin
                bit flip;
                m_press[b] = m_lvl[b] && !m_lvl_prev[b];
                m_lvl_prev[b] = m_lvl[b];
                // Level accepted once the last N synchronized samples all disagree with it.
                m_win[b].push_back(m_h2[b]);
                if (m_win[b].size() > N) void'(m_win[b].pop_front());
                m_h2[b] = m_h1[b];
                m_h1[b] = m_raw[b];
                flip = (m_win[b].size() == N);
                foreach (m_win[b][k]) if (m_win[b][k] == m_lvl[b]) flip = 0;
                if (flip) m_lvl[b] = !m_lvl[b];
            end
        end
    end

    always @(negedge clk) begin
        if (en && reset_) begin
            check("model_digb", digb_word(), (m_d[3] << 12) | (m_d[2] << 8) | (m_d[1] << 4) | m_d[0]);
            check("model_prg", int'(prg), int'(m_mode == 1));
            check("model_load", int'(load), int'(m_mode == 2));
            check("model_edit_pos", int'(edit_pos), m_pos);
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_btn(input int b, input logic v);
        case (b)
            0: btn_mode = v;
            1: btn_next = v;
            default: btn_inc = v;
        endcase
    endtask

    task automatic press(input int b);
        @(negedge clk);
        set_btn(b, 1'b1);
        repeat (N + 6) @(negedge clk);
        set_btn(b, 1'b0);
        repeat (N + 6) @(negedge clk);
    endtask

    task automatic set_dig(input logic [3:0] d3, input logic [3:0] d2,
                           input logic [3:0] d1, input logic [3:0] d0);
        Dig3 = d3; Dig2 = d2; Dig1 = d1; Dig0 = d0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nload;
        int hold[3];

        repeat (3) @(negedge clk);
        check("rst_prg", int'(prg), 0);
        check("rst_load", int'(load), 0);
        check("rst_digb", digb_word(), 0);
        check("rst_pos", int'(edit_pos), 3);
        reset_ = 1'b1;
        en = 1;

        // Short glitch on mode must not start an edit.
        @(negedge clk);
        btn_mode = 1'b1;
        repeat (3) @(negedge clk);
        btn_mode = 1'b0;
        repeat (12) @(negedge clk);
        check("glitch_prg", int'(prg), 0);

        // Out-of-range snapshot digits load as 0.
        set_dig(4'd3, 4'd7, 4'd9, 4'd12);
        press(0);
        check("snap_clip", digb_word(), 16'h0700);
        press(0);

        // Press latency: prg rises on edge N+4 after the first high sample.
        set_dig(4'd1, 4'd2, 4'd3, 4'd4);
        @(negedge clk);
        btn_mode = 1'b1;
        repeat (N + 3) @(posedge clk);
        #1 check("lat_prg_early", int'(prg), 0);
        @(posedge clk);
        #1 check("lat_prg", int'(prg), 1);
        repeat (N + 6) @(negedge clk);
        btn_mode = 1'b0;
        repeat (N + 6) @(negedge clk);
        check("enter_digb", digb_word(), 16'h1234);
        check("enter_pos", int'(edit_pos), 3);
        press(0);

        // Hours tens step to 2 clamps hours units, then wraps.
        set_dig(4'd1, 4'd9, 4'd5, 4'd0);
        press(0);
        press(2);
        check("inc_ht_clamp", digb_word(), 16'h2350);
        press(2);
        check("inc_ht_wrap", digb_word(), 16'h0350);
        press(1);
        press(1);
        check("pos_mt", int'(edit_pos), 1);
        press(2);
        check("inc_mt_wrap", digb_word(), 16'h0300);
        press(0);
        check("abort_prg", int'(prg), 0);
        check("abort_keep", digb_word(), 16'h0300);

        // Full edit ending in a commit.
        set_dig(4'd2, 4'd3, 4'd5, 4'd9);
        press(0);
        press(1);
        press(1);
        press(1);
        check("pos_mu", int'(edit_pos), 0);
        press(2);
        check("inc_mu_wrap", digb_word(), 16'h2350);
        nload = 0;
        @(negedge clk);
        btn_next = 1'b1;
        repeat (N + 6) begin
            @(negedge clk);
            if (load) begin
                nload++;
                check("load_digb", digb_word(), 16'h2350);
                check("load_prg", int'(prg), 0);
            end
        end
        btn_next = 1'b0;
        repeat (N + 6) begin
            @(negedge clk);
            if (load) nload++;
        end
        check("load_count", nload, 1);

        // mode + inc together: mode wins, digit untouched, no load.
        press(0);
        check("edit2_digb", digb_word(), 16'h2359);
        nload = 0;
        @(negedge clk);
        btn_mode = 1'b1;
        btn_inc = 1'b1;
        repeat (N + 6) begin
            @(negedge clk);
            if (load) nload++;
        end
        btn_mode = 1'b0;
        btn_inc = 1'b0;
        repeat (N + 6) @(negedge clk);
        check("prio_prg", int'(prg), 0);
        check("prio_digb", digb_word(), 16'h2359);
        check("prio_noload", nload, 0);

        // Asynchronous reset mid-edit.
        press(0);
        press(1);
        press(1);
        check("pre_rst_pos", int'(edit_pos), 1);
        @(negedge clk);
        #2 reset_ = 1'b0;
        #1;
        check("arst_prg", int'(prg), 0);
        check("arst_digb", digb_word(), 0);
        check("arst_pos", int'(edit_pos), 3);
        check("arst_load", int'(load), 0);
        @(negedge clk);
        reset_ = 1'b1;

        // Randomized button traffic, including glitches, holds and out-of-range time.
        for (int b = 0; b < 3; b++) hold[b] = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int b = 0; b < 3; b++) begin
                if (hold[b] == 0) begin
                    if (b == 0) set_btn(b, ($urandom_range(0, 5) == 0));
                    else set_btn(b, logic'($urandom_range(0, 1)));
                    hold[b] = $urandom_range(1, 14);
                end else begin
                    hold[b]--;
                end
            end
            if ($urandom_range(0, 49) == 0)
                set_dig(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                        4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end
        btn_mode = 1'b0;
        btn_next = 1'b0;
        btn_inc = 1'b0;
        repeat (20) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
